// File: rtl/regset_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the regset initiator.
// Defining READBACK_CHECK_EN adds the WR_CHECK state to the state enum.
package regset_pkg;

    localparam int DEF_DW = 4;
    localparam int DEF_AW = 3;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WRITE     = 3'd1,
        READ      = 3'd2,
        READ_LAST = 3'd3
`ifdef READBACK_CHECK_EN
        ,
        WR_CHECK  = 3'd4
`endif
    } state_t;

endpackage

// File: rtl/regset_master.sv
`timescale 1ns/1ps
// Initiator for the 8-entry regset: turns host single/burst commands into regset bus cycles.
// Optional macro READBACK_CHECK_EN: read back every written beat and flag differences on Mismatch.
module regset_master
    import regset_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          Cmd_valid,
    output logic          Cmd_ready,
    input  logic          Cmd_rw,
    input  logic [AW-1:0] Cmd_addr,
    input  logic [AW-1:0] Cmd_len,
    input  logic          Wr_valid,
    output logic          Wr_ready,
    input  logic [DW-1:0] Wr_data,
    output logic          Rd_valid,
    output logic [DW-1:0] Rd_data,
    output logic          Done,
    output logic          Mismatch,
    output logic          Rs_RW,
    output logic [AW-1:0] Rs_Address,
    output logic [DW-1:0] Rs_Data_wr,
    input  logic [DW-1:0] Rs_Data_rd
);

    state_t        state;
    logic [AW-1:0] addr_q;
    logic [AW-1:0] cnt_q;
    logic          wr_fin;

`ifdef READBACK_CHECK_EN
    logic          chk_pend;
    logic          mismatch_q;

    assign Mismatch = mismatch_q;
`else
    assign Mismatch = 1'b0;
`endif

    // wr_fin marks the cycle that carries the last beat, so no further beat is taken
    assign Cmd_ready = (state == IDLE) && !Rst;
    assign Wr_ready  = (state == WRITE) && !wr_fin && !Rst;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state      <= IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            wr_fin     <= 1'b0;
            Rs_RW      <= RW_READ;
            Rs_Address <= '0;
            Rs_Data_wr <= '0;
            Rd_valid   <= 1'b0;
            Rd_data    <= '0;
            Done       <= 1'b0;
`ifdef READBACK_CHECK_EN
            chk_pend   <= 1'b0;
            mismatch_q <= 1'b0;
`endif
        end else begin
            Rs_RW    <= RW_READ;
            Done     <= 1'b0;
            Rd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (Cmd_valid) begin
                        addr_q <= Cmd_addr;
                        cnt_q  <= Cmd_len;
                        wr_fin <= 1'b0;
                        if (Cmd_rw == RW_READ) begin
                            Rs_Address <= Cmd_addr;
                            state      <= (Cmd_len == '0) ? READ_LAST : READ;
                        end else begin
                            state <= WRITE;
                        end
                    end
                end
                WRITE: begin
`ifdef READBACK_CHECK_EN
                    // Readback data for the previous beat arrives at this edge
                    if (chk_pend) begin
                        chk_pend <= 1'b0;
                        if (Rs_Data_rd != Rs_Data_wr)
                            mismatch_q <= 1'b1;
                    end
`endif
                    if (wr_fin) begin
                        wr_fin <= 1'b0;
                        Done   <= 1'b1;
                        state  <= IDLE;
                    end else if (Wr_valid) begin
                        Rs_RW      <= RW_WRITE;
                        Rs_Address <= addr_q;
                        Rs_Data_wr <= Wr_data;
                        addr_q     <= addr_q + 1'b1;
                        cnt_q      <= cnt_q - 1'b1;
                        if (cnt_q == '0)
                            wr_fin <= 1'b1;
`ifdef READBACK_CHECK_EN
                        state <= WR_CHECK;
`endif
                    end
                end
`ifdef READBACK_CHECK_EN
                WR_CHECK: begin
                    chk_pend <= 1'b1;
                    state    <= WRITE;
                end
`endif
                READ: begin
                    Rd_valid   <= 1'b1;
                    Rd_data    <= Rs_Data_rd;
                    Rs_Address <= Rs_Address + 1'b1;
                    cnt_q      <= cnt_q - 1'b1;
                    if (cnt_q == AW'(1))
                        state <= READ_LAST;
                end
                READ_LAST: begin
                    Rd_valid <= 1'b1;
                    Rd_data  <= Rs_Data_rd;
                    Done     <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
